pwm_speed_ctrl: RTL and testbench

//   Speed-command scheduler in front of the pwm_speed generator. Arbitrates 8-bit speed

---
 rtl/pwm_ctrl_pkg.sv | 20 ++
 rtl/pwm_speed_ctrl_arb.sv | 27 ++
 rtl/pwm_speed_ctrl.sv | 146 ++++++++++++++
 tb/tb_pwm_speed_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the speed-command scheduler.
// Optional watchdog is enabled with PWM_SPEED_CTRL_WDOG_EN (see pwm_speed_ctrl).
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RAMP     = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  localparam int SPEED_W = 8;
  localparam logic [SPEED_W-1:0] NEUTRAL_SPEED = 8'd128;

  // All-ones pattern of width w, used as the "no requester accepted yet" index.
  function automatic int unsigned grant_none(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_speed_ctrl_arb.sv
// Fixed-priority arbiter: lowest asserted valid index wins. Purely combinational.
module pwm_prio_arb #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ) + 1
) (
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_speed_ctrl.sv
// Speed-command scheduler: arbitrates requesters, slew-limits speed_out toward the target.
// Define PWM_SPEED_CTRL_WDOG_EN to add the command watchdog and FAILSAFE state.
module pwm_speed_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 8,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 1000,
  parameter int WDOG_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         speed_out,
  output logic                      at_target,
  output logic [$clog2(NUM_REQ):0]  grant_idx,
  output logic                      timeout
);

  localparam int IDX_W = $clog2(NUM_REQ) + 1;
  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [IDX_W-1:0]  GRANT_NONE = IDX_W'(grant_none(IDX_W));
  localparam logic [DATA_W-1:0] NEUTRAL =
      (DATA_W == SPEED_W) ? DATA_W'(NEUTRAL_SPEED) : (DATA_W'(1) << (DATA_W - 1));
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic signed [DATA_W:0] STEP_S = (DATA_W + 1)'(RAMP_STEP);

  state_t              state;
  logic [DATA_W-1:0]   target;
  logic [PRE_W-1:0]    presc;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                accept;
  logic [DATA_W-1:0]   acc_data;
  logic                ramping;
  logic                tick;
  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]   step_val;
  logic [DATA_W-1:0]   speed_nxt;
  logic                wdog_fire;

  pwm_prio_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid (req_valid),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign req_ready = (enable && state != ST_DISABLED && arb_any) ? arb_grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) acc_data = acc_data | req_data[i*DATA_W +: DATA_W];
    end
  end

  assign ramping = (state == ST_RAMP) || (state == ST_FAILSAFE);
  assign tick    = ramping && (presc == PRE_LAST);

  // Diff is one bit wider than the data so the step can never wrap past the target.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, speed_out});
    if (diff > STEP_S)       step_val = speed_out + DATA_W'(RAMP_STEP);
    else if (diff < -STEP_S) step_val = speed_out - DATA_W'(RAMP_STEP);
    else                     step_val = target;
  end

  assign speed_nxt = tick ? step_val : speed_out;

`ifdef PWM_SPEED_CTRL_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog;

  assign wdog_fire = ((state == ST_HOLD) || (state == ST_RAMP)) &&
                     (wdog == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else if (!enable || accept) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else if (wdog_fire) begin
      wdog    <= '0;
      timeout <= 1'b1;
    end else if ((state == ST_HOLD) || (state == ST_RAMP)) begin
      wdog    <= wdog + 1'b1;
    end else begin
      wdog    <= '0;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 0);
  assign wdog_fire   = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DISABLED;
      speed_out <= NEUTRAL;
      target    <= NEUTRAL;
      at_target <= 1'b1;
      grant_idx <= GRANT_NONE;
      presc     <= '0;
    end else if (!enable) begin
      state     <= ST_DISABLED;
      speed_out <= NEUTRAL;
      target    <= NEUTRAL;
      at_target <= 1'b1;
      presc     <= '0;
    end else if (state == ST_DISABLED) begin
      state <= ST_HOLD;
    end else begin
      presc     <= (ramping && !tick) ? presc + 1'b1 : '0;
      speed_out <= speed_nxt;
      // A tick in the accept cycle still steps toward the old target.
      if (accept) begin
        target    <= acc_data;
        grant_idx <= arb_idx;
        at_target <= (speed_nxt == acc_data);
        state     <= (speed_nxt == acc_data) ? ST_HOLD : ST_RAMP;
      end else if (wdog_fire) begin
        target    <= NEUTRAL;
        at_target <= (speed_nxt == NEUTRAL);
        state     <= ST_FAILSAFE;
      end else begin
        at_target <= (speed_nxt == target);
        if (state == ST_RAMP && speed_nxt == target) state <= ST_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Directed bench for pwm_speed_ctrl with RAMP_STEP=4, RAMP_DIV=4, WDOG_CYCLES=100.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_pwm_speed_ctrl;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    speed_out;
  logic             at_target;
  logic [IW-1:0]    grant_idx;
  logic             timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] max_spd;

  pwm_speed_ctrl #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .RAMP_STEP   (4),
    .RAMP_DIV    (4),
    .WDOG_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .speed_out (speed_out),
    .at_target (at_target),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (speed_out > max_spd) max_spd = speed_out;
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_data[i*DW +: DW]  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    max_spd   = '0;
    set_req(1, 8'd99);
    run(2);
    #1;
    check("rst_speed",  32'(speed_out), 32'd128);
    check("rst_at_tgt", 32'(at_target), 32'd1);
    check("rst_gidx",   32'(grant_idx), 32'd7);
    check("rst_tmo",    32'(timeout),   32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);

    rst_n     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    run(2);
    check("idle_speed",  32'(speed_out), 32'd128);
    check("idle_at_tgt", 32'(at_target), 32'd1);
    check("idle_ready",  32'(req_ready), 32'd0);

    // Single requester ramps 128 -> 140 in three 4-cycle ticks.
    set_req(1, 8'd140);
    #1 check("r1_ready", 32'(req_ready), 32'b010);
    run(1);
    req_valid = '0;
    check("r1_gidx",   32'(grant_idx), 32'd1);
    check("r1_at_tgt", 32'(at_target), 32'd0);
    run(3);
    check("r1_pre_tick", 32'(speed_out), 32'd128);
    run(1);
    check("r1_step1", 32'(speed_out), 32'd132);
    run(4);
    check("r1_step2", 32'(speed_out), 32'd136);
    run(4);
    check("r1_step3",  32'(speed_out), 32'd140);
    check("r1_at_tgt2", 32'(at_target), 32'd1);
    run(8);
    check("r1_hold", 32'(speed_out), 32'd140);

    // Simultaneous requests: 0 wins, 2 waits and is taken the next cycle.
    set_req(0, 8'd60);
    set_req(2, 8'd200);
    #1 check("arb_ready0", 32'(req_ready), 32'b001);
    run(1);
    req_valid[0] = 1'b0;
    #1 check("arb_ready2", 32'(req_ready), 32'b100);
    check("arb_gidx0", 32'(grant_idx), 32'd0);
    run(1);
    req_valid = '0;
    check("arb_gidx2", 32'(grant_idx), 32'd2);
    run(3);
    check("arb_step1", 32'(speed_out), 32'd144);
    run(4);
    check("arb_step2", 32'(speed_out), 32'd148);

    // Disable mid-ramp snaps to neutral and blocks requests.
    enable = 1'b0;
    set_req(2, 8'd50);
    run(1);
    #1;
    check("dis_speed",  32'(speed_out), 32'd128);
    check("dis_at_tgt", 32'(at_target), 32'd1);
    check("dis_ready",  32'(req_ready), 32'd0);
    req_valid = '0;
    enable    = 1'b1;
    run(1);

    // Ramp up to 144, then retarget down to 130 mid-ramp.
    set_req(2, 8'd200);
    #1 check("rt_ready", 32'(req_ready), 32'b100);
    run(1);
    req_valid = '0;
    max_spd   = '0;
    run(16);
    check("rt_peak", 32'(speed_out), 32'd144);
    set_req(1, 8'd130);
    run(1);
    req_valid = '0;
    check("rt_gidx", 32'(grant_idx), 32'd1);
    run(3);
    check("rt_dn1", 32'(speed_out), 32'd140);
    run(4);
    check("rt_dn2", 32'(speed_out), 32'd136);
    run(4);
    check("rt_dn3", 32'(speed_out), 32'd132);
    run(4);
    check("rt_dn4",    32'(speed_out), 32'd130);
    check("rt_at_tgt", 32'(at_target), 32'd1);
    check("rt_max",    32'(max_spd),   32'd144);

    // Accepting the current speed stays put.
    set_req(0, 8'd130);
    run(1);
    req_valid = '0;
    check("eq_gidx",   32'(grant_idx), 32'd0);
    check("eq_at_tgt", 32'(at_target), 32'd1);
    run(8);
    check("eq_speed", 32'(speed_out), 32'd130);

`ifdef PWM_SPEED_CTRL_WDOG_EN
    set_req(2, 8'd180);
    run(1);
    req_valid = '0;
    run(99);
    check("wd_pre_tmo",   32'(timeout),   32'd0);
    check("wd_pre_speed", 32'(speed_out), 32'd180);
    run(1);
    check("wd_tmo", 32'(timeout), 32'd1);
    run(52);
    check("wd_neutral", 32'(speed_out), 32'd128);
    check("wd_tmo_held", 32'(timeout),  32'd1);
    set_req(1, 8'd150);
    run(1);
    req_valid = '0;
    check("wd_exit_tmo",  32'(timeout),   32'd0);
    check("wd_exit_gidx", 32'(grant_idx), 32'd1);
    run(3);
    check("wd_exit_step", 32'(speed_out), 32'd132);
`else
    run(120);
    check("no_wdog_tmo",   32'(timeout),   32'd0);
    check("no_wdog_speed", 32'(speed_out), 32'd130);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
